// File: rtl/spi_seg_pkg.sv
// Shared definitions for the SPI segment-controller receive path.
//   state_e        : frame decoder FSM states
//   FRAME_BITS     : SCK rises in a complete command + data frame
//   CMD_WR_BIT     : command bit that marks a register write
//   DEV_ID_DEFAULT : ID byte returned on MISO during the command byte
package spi_seg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StSkip
    } state_e;

    localparam int unsigned FRAME_BITS     = 16;
    localparam int unsigned CMD_WR_BIT     = 7;
    localparam logic [7:0]  DEV_ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_segment_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus edge pulses.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din_i      : asynchronous input
//   sync_o     : synchronised level (SYNC_STAGES clk behind the pin)
//   rise_o     : one-clk pulse on the 0->1 transition of sync_o
//   fall_o     : one-clk pulse on the 1->0 transition of sync_o
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev_q resets to the same value as the chain so reset release never
    // produces a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_segment_rx.sv
// SPI mode-0 slave front end for the segment controller.
// Oversamples SCK/CS_N/MOSI on clk and decodes 16-bit frames (command byte,
// data byte) into single-cycle register-write strobes. MISO returns DEV_ID
// during the command byte and the accepted-write count during the data byte.
//   clk, rst_n : system clock (>= 8x SCK), asynchronous active-low reset
//   spi_sck    : SPI clock, idle low
//   spi_cs_n   : chip select, active low
//   spi_mosi   : serial data in, MSB first
//   spi_miso   : serial data out, MSB first
//   wr_valid   : one-clk pulse per accepted write frame
//   wr_addr    : register index, valid with wr_valid and then held
//   wr_data    : register data, valid with wr_valid and then held
//   frame_err  : one-clk pulse when CS_N rises mid-frame
module spi_segment_rx
    import spi_seg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 3,
    parameter logic [7:0]  DEV_ID      = DEV_ID_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_err
);

    // ---------------------------------------------------------------------
    // Input synchronisation
    // ---------------------------------------------------------------------
    logic unused_sck_level;
    logic sck_rise, sck_fall;
    logic cs_sync, cs_rise, cs_fall;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sck (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (spi_sck),
        .sync_o (unused_sck_level),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (spi_cs_n),
        .sync_o (cs_sync),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI has the same depth as SCK, so on a synced SCK rise it shows the
    // pin value present at the pin-level SCK rise.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q;
    logic [6:0]        sh_q;
    logic              cmd_wr_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [7:0]        tx_q;
    logic [7:0]        wr_cnt_q;
    logic              wr_valid_q, frame_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    logic       in_frame;
    logic       counted_rise, counted_fall;
    logic [7:0] sh_next;
    logic       last_cmd_bit, last_data_bit;
    logic       wr_fire, abort;

    assign in_frame = (state_q == StCmd) || (state_q == StData);

    // cs_sync is already high in the cycle that cs_rise fires, so an SCK
    // edge coinciding with CS_N deassertion is never counted.
    assign counted_rise = sck_rise & ~cs_sync & in_frame;
    assign counted_fall = sck_fall & ~cs_sync & in_frame;

    assign sh_next       = {sh_q, mosi_sync};
    assign last_cmd_bit  = counted_rise && (state_q == StCmd) && (bit_cnt_q == 4'd7);
    assign last_data_bit = counted_rise && (state_q == StData) &&
                           (bit_cnt_q == 4'(FRAME_BITS - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (cs_fall)       state_d = StCmd;
                StCmd:   if (last_cmd_bit)  state_d = StData;
                StData:  if (last_data_bit) state_d = StSkip;
                StSkip:  state_d = StSkip;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        spi_miso = in_frame ? tx_q[7] : 1'b0;
        wr_fire  = last_data_bit & cmd_wr_q;
        // A bare CS_N toggle with no clocked bits is not an error.
        abort    = cs_rise & in_frame & (bit_cnt_q != 4'd0);
    end

    // Shift, count and strobe datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            tx_q        <= '0;
            wr_cnt_q    <= '0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_valid_q  <= wr_fire;
            frame_err_q <= abort;

            if ((state_q == StIdle) && cs_fall) begin
                bit_cnt_q <= '0;
                tx_q      <= DEV_ID;
            end

            if (counted_rise) begin
                sh_q      <= sh_next[6:0];
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end

            if (last_cmd_bit) begin
                cmd_wr_q   <= sh_next[CMD_WR_BIT];
                cmd_addr_q <= sh_next[ADDR_W-1:0];
            end

            // wr_cnt only moves at the end of a frame, so at the 8th fall it
            // still holds the frame-start value.
            if (counted_fall) begin
                if (bit_cnt_q == 4'd8) begin
                    tx_q <= wr_cnt_q;
                end else begin
                    tx_q <= {tx_q[6:0], 1'b0};
                end
            end

            if (wr_fire) begin
                wr_addr_q <= cmd_addr_q;
                wr_data_q <= sh_next;
                wr_cnt_q  <= wr_cnt_q + 8'd1;
            end
        end
    end

    assign wr_valid  = wr_valid_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
